// File: rtl/psram_pkg.sv
// psram_pkg
//   Shared types for the PSRAM byte adapter: the queued request record,
//   the adapter FSM encoding, and the byte-address field positions.
//   Byte address layout: [23] bank, [22:1] 16-bit word address, [0] byte lane.
package psram_pkg;

    localparam int PSRAM_ADDR_W = 24;
    localparam int PSRAM_WORD_W = 22;
    localparam int BANK_BIT     = 23;
    localparam int LANE_BIT     = 0;

    typedef struct packed {
        logic                    write;
        logic [PSRAM_ADDR_W-1:0] addr;
        logic [7:0]              wdata;
    } psram_byte_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } fsm_t;

    function automatic logic [PSRAM_WORD_W-1:0] word_addr(input logic [PSRAM_ADDR_W-1:0] addr);
        return addr[BANK_BIT-1:1];
    endfunction

endpackage

// File: rtl/psram_req_fifo.sv
// psram_req_fifo
//   Synchronous request queue of psram_byte_req_t entries.
//   Ports:
//     clk, reset_n        clock, async active-low reset (clears pointers/count)
//     push, push_data     enqueue when push && !full
//     pop                 dequeue head when pop && !empty
//     head                current head entry (combinational read)
//     full, empty         occupancy flags
//   DEPTH must be a power of two so the pointers wrap by natural overflow.
module psram_req_fifo
    import psram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  psram_byte_req_t push_data,
    input  logic            pop,
    output psram_byte_req_t head,
    output logic            full,
    output logic            empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    psram_byte_req_t  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/psram_byte_adapter.sv
// psram_byte_adapter
//   Queues byte read/write requests from the core, turns each into a 16-bit
//   word access with byte lanes, issues single-cycle strobes to the async
//   PSRAM controller and returns read bytes in request order.
//   Ports:
//     clk, reset_n                  clock, async active-low reset
//     req_valid/req_ready           core request handshake
//     req_write/req_addr/req_wdata  request contents
//     rsp_valid/rsp_rdata           read byte return (one-cycle pulse)
//     wr_done                       write retired (one-cycle pulse)
//     mem_*                         controller interface (all registered outputs)
//
//   state     | meaning
//   IDLE      | wait for a queued request and controller not busy; load mem_* fields
//   ISSUE     | raise the strobe for the next cycle, pop the queue, latch lane/kind
//   WAIT_BUSY | strobe is on the wire; controller registers busy this edge
//   WAIT_DONE | read: wait for read_avail; write: wait for busy to fall
module psram_byte_adapter
    import psram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = PSRAM_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [7:0]              req_wdata,
    output logic                    rsp_valid,
    output logic [7:0]              rsp_rdata,
    output logic                    wr_done,
    output logic                    mem_bank_sel,
    output logic [PSRAM_WORD_W-1:0] mem_addr,
    output logic                    mem_write_en,
    output logic                    mem_read_en,
    output logic [15:0]             mem_data_in,
    output logic                    mem_write_high,
    output logic                    mem_write_low,
    input  logic                    mem_read_avail,
    input  logic [15:0]             mem_data_out,
    input  logic                    mem_busy
);

    fsm_t                    state_q, state_d;
    logic                    ready_q;
    logic                    bank_q, bank_d;
    logic [PSRAM_WORD_W-1:0] addr_q, addr_d;
    logic [15:0]             data_q, data_d;
    logic                    high_q, high_d;
    logic                    low_q, low_d;
    logic                    wen_q, wen_d;
    logic                    ren_q, ren_d;
    logic                    lane_q, lane_d;
    logic                    kind_q, kind_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [7:0]              rsp_rdata_q, rsp_rdata_d;
    logic                    wr_done_q, wr_done_d;

    psram_byte_req_t push_data;
    psram_byte_req_t head;
    logic            full;
    logic            empty;
    logic            pop;

    // ready_q holds req_ready low while in reset and for the first edge after it.
    assign req_ready = ready_q && !full;
    assign push_data = '{write: req_write, addr: req_addr, wdata: req_wdata};

    psram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (req_valid && req_ready),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        addr_d      = addr_q;
        data_d      = data_q;
        high_d      = high_q;
        low_d       = low_q;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        lane_d      = lane_q;
        kind_d      = kind_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        wr_done_d   = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !mem_busy) begin
                    state_d = ISSUE;
                    bank_d  = head.addr[BANK_BIT];
                    addr_d  = word_addr(head.addr);
                    data_d  = {head.wdata, head.wdata};
                    high_d  = head.addr[LANE_BIT];
                    low_d   = !head.addr[LANE_BIT];
                end
            end
            ISSUE: begin
                wen_d   = head.write;
                ren_d   = !head.write;
                pop     = 1'b1;
                lane_d  = head.addr[LANE_BIT];
                kind_d  = head.write;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (kind_q) begin
                    if (!mem_busy) begin
                        wr_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (mem_read_avail) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lane_q ? mem_data_out[15:8] : mem_data_out[7:0];
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            bank_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            high_q      <= 1'b0;
            low_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            lane_q      <= 1'b0;
            kind_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            high_q      <= high_d;
            low_q       <= low_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            lane_q      <= lane_d;
            kind_q      <= kind_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign mem_bank_sel   = bank_q;
    assign mem_addr       = addr_q;
    assign mem_data_in    = data_q;
    assign mem_write_high = high_q;
    assign mem_write_low  = low_q;
    assign mem_write_en   = wen_q;
    assign mem_read_en    = ren_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign wr_done        = wr_done_q;

endmodule

// File: tb/tb_psram_byte_adapter.sv
// tb_psram_byte_adapter
//   Directed bench for psram_byte_adapter with a behavioural PSRAM controller:
//   a strobe seen at a clock edge makes busy high from that edge for busy_len
//   cycles; read_avail pulses in the last busy cycle together with the word.
module tb_psram_byte_adapter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        wr_done;
    logic        mem_bank_sel;
    logic [21:0] mem_addr;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [15:0] mem_data_in;
    logic        mem_write_high;
    logic        mem_write_low;
    logic        mem_read_avail;
    logic [15:0] mem_data_out;
    logic        mem_busy;

    int tests = 0;
    int fails = 0;

    psram_byte_adapter #(.FIFO_DEPTH(4), .ADDR_W(24)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .wr_done        (wr_done),
        .mem_bank_sel   (mem_bank_sel),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_data_in    (mem_data_in),
        .mem_write_high (mem_write_high),
        .mem_write_low  (mem_write_low),
        .mem_read_avail (mem_read_avail),
        .mem_data_out   (mem_data_out),
        .mem_busy       (mem_busy)
    );

    always #5 clk = ~clk;

    // ---------------- controller model ----------------
    int          busy_len = 3;
    bit          rand_busy = 1'b0;
    logic        busy_force = 1'b0;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic        m_read = 1'b0;
    logic [15:0] m_rword = '0;
    logic [15:0] model_mem [logic [22:0]];
    logic [22:0] m_key;
    logic [15:0] m_word;

    assign mem_busy       = m_busy | busy_force;
    assign mem_read_avail = m_busy && m_read && (m_cnt == 1);
    assign mem_data_out   = mem_read_avail ? m_rword : 16'h0000;

    always @(posedge clk) begin
        if (mem_write_en || mem_read_en) begin
            m_key  = {mem_bank_sel, mem_addr};
            m_word = model_mem.exists(m_key) ? model_mem[m_key] : 16'h0000;
            if (mem_write_en) begin
                if (mem_write_high) m_word[15:8] = mem_data_in[15:8];
                if (mem_write_low)  m_word[7:0]  = mem_data_in[7:0];
                model_mem[m_key] = m_word;
            end
            m_rword <= m_word;
            m_read  <= mem_read_en;
            m_busy  <= 1'b1;
            m_cnt   <= rand_busy ? int'($urandom_range(20, 1)) : busy_len;
        end else if (m_busy) begin
            if (m_cnt <= 1) m_busy <= 1'b0;
            m_cnt <= m_cnt - 1;
        end
    end

    // ---------------- monitors ----------------
    logic [7:0] rsp_q[$];
    int         wr_cnt = 0;
    int         wr_busy_cnt = 0;
    int         strobe_cnt = 0;
    int         viol_cnt = 0;
    logic       prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid) rsp_q.push_back(rsp_rdata);
        if (wr_done) begin
            wr_cnt++;
            if (mem_busy) wr_busy_cnt++;
        end
        if (mem_write_en || mem_read_en) begin
            strobe_cnt++;
            if (mem_busy) viol_cnt++;
            if (prev_strobe) viol_cnt++;
            if (mem_write_en && mem_read_en) viol_cnt++;
        end
        prev_strobe = mem_write_en || mem_read_en;
    end

    // ---------------- stimulus helpers ----------------
    // Call at a negedge; returns #1 after the edge on which the request transferred.
    task automatic push(input logic w, input logic [23:0] a, input logic [7:0] d);
        int t = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles, required 1", t);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int n);
        int t = 0;
        while (rsp_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_wr(input int n);
        int t = 0;
        while (wr_cnt < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
    endtask

    function automatic logic [7:0] pop_rsp();
        if (rsp_q.size() > 0) return rsp_q.pop_front();
        return 8'hxx;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
        tests++; if (wr_done !== 1'b0) begin fails++; $display("FAIL rst_wr_done: got %b want 0", wr_done); end
        tests++;
        if ({mem_bank_sel, mem_addr, mem_write_en, mem_read_en, mem_data_in, mem_write_high, mem_write_low} !== '0) begin
            fails++;
            $display("FAIL rst_mem_outputs: got bank=%b addr=%h we=%b re=%b din=%h hi=%b lo=%b want all 0",
                     mem_bank_sel, mem_addr, mem_write_en, mem_read_en, mem_data_in, mem_write_high, mem_write_low);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write();
        int base = wr_cnt;
        busy_len = 3;
        push(1'b1, 24'h000003, 8'hA5);
        @(negedge clk);
        @(negedge clk);
        tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL wr_strobe_early: got %b want 0 at push+1", mem_write_en); end
        @(negedge clk);
        tests++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0) begin
            fails++; $display("FAIL wr_strobe: got we=%b re=%b want we=1 re=0 at push+2", mem_write_en, mem_read_en); end
        tests++; if (mem_addr !== 22'h000001 || mem_bank_sel !== 1'b0) begin
            fails++; $display("FAIL wr_addr: got addr=%h bank=%b want 000001 bank 0", mem_addr, mem_bank_sel); end
        tests++; if (mem_data_in !== 16'hA5A5) begin fails++; $display("FAIL wr_data: got %h want a5a5", mem_data_in); end
        tests++; if (mem_write_high !== 1'b1 || mem_write_low !== 1'b0) begin
            fails++; $display("FAIL wr_lanes: got hi=%b lo=%b want hi=1 lo=0", mem_write_high, mem_write_low); end
        @(negedge clk);
        tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL wr_strobe_width: got %b want 0", mem_write_en); end
        wait_wr(base + 1);
        repeat (6) @(negedge clk);
        tests++; if (wr_cnt !== base + 1) begin fails++; $display("FAIL wr_done_count: got %0d want %0d", wr_cnt, base + 1); end
        tests++; if (wr_busy_cnt !== 0) begin fails++; $display("FAIL wr_done_while_busy: got %0d want 0", wr_busy_cnt); end
    endtask

    task automatic test_read();
        logic [7:0] got;
        int base = wr_cnt;
        busy_len = 2;
        push(1'b1, 24'h800002, 8'h34);
        push(1'b1, 24'h800003, 8'h12);
        wait_wr(base + 2);
        repeat (3) @(negedge clk);
        push(1'b0, 24'h800002, 8'h00);
        repeat (3) @(negedge clk);
        tests++; if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin
            fails++; $display("FAIL rd_strobe: got re=%b we=%b want re=1 we=0 at push+2", mem_read_en, mem_write_en); end
        tests++; if (mem_bank_sel !== 1'b1 || mem_addr !== 22'h000001) begin
            fails++; $display("FAIL rd_addr: got bank=%b addr=%h want bank 1 addr 000001", mem_bank_sel, mem_addr); end
        wait_rsp(1);
        got = pop_rsp();
        tests++; if (got !== 8'h34) begin fails++; $display("FAIL rd_low_lane: got %h want 34", got); end
        push(1'b0, 24'h800003, 8'h00);
        wait_rsp(1);
        got = pop_rsp();
        tests++; if (got !== 8'h12) begin fails++; $display("FAIL rd_high_lane: got %h want 12", got); end
    endtask

    task automatic test_write_read();
        logic [7:0] got;
        busy_len = 4;
        @(negedge clk);
        push(1'b1, 24'h000010, 8'h5A);
        push(1'b0, 24'h000010, 8'h00);
        wait_rsp(1);
        got = pop_rsp();
        tests++; if (got !== 8'h5A) begin fails++; $display("FAIL wr_then_rd: got %h want 5a", got); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        int wbase;
        int sbase;
        repeat (4) @(negedge clk);
        wbase = wr_cnt;
        sbase = strobe_cnt;
        busy_len   = 2;
        busy_force = 1'b1;
        @(negedge clk);
        push(1'b1, 24'h000020, 8'h11);
        push(1'b1, 24'h000021, 8'h22);
        push(1'b0, 24'h000020, 8'h00);
        push(1'b1, 24'h000020, 8'h33);
        @(negedge clk);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready: got %b want 0", req_ready); end
        tests++; if (strobe_cnt !== sbase) begin fails++; $display("FAIL b2b_no_strobe_busy: got %0d strobes want %0d", strobe_cnt, sbase); end
        fork
            push(1'b0, 24'h000020, 8'h00);
            begin
                repeat (10) @(negedge clk);
                busy_force = 1'b0;
            end
        join
        wait_rsp(2);
        wait_wr(wbase + 3);
        repeat (8) @(negedge clk);
        got = pop_rsp();
        tests++; if (got !== 8'h11) begin fails++; $display("FAIL b2b_rsp0: got %h want 11", got); end
        got = pop_rsp();
        tests++; if (got !== 8'h33) begin fails++; $display("FAIL b2b_rsp1: got %h want 33", got); end
        tests++; if (wr_cnt !== wbase + 3) begin fails++; $display("FAIL b2b_wr_count: got %0d want %0d", wr_cnt, wbase + 3); end
        tests++; if (strobe_cnt !== sbase + 5) begin fails++; $display("FAIL b2b_strobes: got %0d want %0d", strobe_cnt, sbase + 5); end
    endtask

    task automatic test_strobe_spacing();
        logic [7:0] got;
        int sbase = strobe_cnt;
        rand_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b1, 24'h000100 + 24'(i), 8'h40 + 8'(i));
        for (int i = 0; i < 4; i++) push(1'b0, 24'h000100 + 24'(i), 8'h00);
        wait_rsp(4);
        repeat (25) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            got = pop_rsp();
            tests++; if (got !== 8'h40 + 8'(i)) begin fails++; $display("FAIL spacing_rsp%0d: got %h want %h", i, got, 8'h40 + 8'(i)); end
        end
        tests++; if (strobe_cnt !== sbase + 8) begin fails++; $display("FAIL spacing_strobes: got %0d want %0d", strobe_cnt, sbase + 8); end
        tests++; if (viol_cnt !== 0) begin fails++; $display("FAIL spacing_violations: got %0d want 0", viol_cnt); end
        rand_busy = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int t = 0;
        int wbase = wr_cnt;
        busy_len = 15;
        push(1'b0, 24'h800002, 8'h00);
        while (!mem_read_en && t < 20) begin @(negedge clk); t++; end
        tests++; if (mem_read_en !== 1'b1) begin fails++; $display("FAIL mid_strobe_seen: got %b want 1", mem_read_en); end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || wr_done !== 1'b0) begin
            fails++; $display("FAIL mid_rst_core: got ready=%b rv=%b rd=%h wd=%b want 0/0/00/0", req_ready, rsp_valid, rsp_rdata, wr_done); end
        tests++; if ({mem_bank_sel, mem_addr, mem_read_en, mem_write_en, mem_data_in} !== '0) begin
            fails++; $display("FAIL mid_rst_mem: got bank=%b addr=%h re=%b we=%b din=%h want all 0",
                              mem_bank_sel, mem_addr, mem_read_en, mem_write_en, mem_data_in); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        busy_len = 3;
        @(negedge clk);
        push(1'b0, 24'h800003, 8'h00);
        wait_rsp(1);
        repeat (20) @(negedge clk);
        tests++; if (rsp_q.size() !== 1) begin fails++; $display("FAIL mid_rsp_count: got %0d want 1", rsp_q.size()); end
        got = pop_rsp();
        tests++; if (got !== 8'h12) begin fails++; $display("FAIL mid_rsp_data: got %h want 12", got); end
        tests++; if (viol_cnt !== 0) begin fails++; $display("FAIL mid_violations: got %0d want 0", viol_cnt); end
        tests++; if (wr_cnt !== wbase) begin fails++; $display("FAIL mid_wr_done: got %0d want %0d", wr_cnt, wbase); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_write_read();
        test_back_to_back();
        test_strobe_spacing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
